// File: rtl/bus_cycle_initiator.sv
// Bus cycle initiator for the I/O-mapper bus.
// This module acts as a CPU-side bus master. It turns single read/write
// requests into AS/RWb/ADDR/data bus cycles, then waits for the decoder's
// DTAC acknowledge. An acknowledge that never arrives ends the cycle with
// a timeout.
// Every bus-facing output is registered. The next-state logic computes
// next-cycle output values, so the bus pins change cleanly on SYSCLK edges.
module bus_cycle_initiator #(
  parameter int ADDR_SETUP = 5,    // SETUP ticks with ADDR valid and AS high (>=2)
  parameter int AS_MIN     = 10,   // minimum AS-low ticks (>=3)
  parameter int TIMEOUT    = 256   // AS-low ticks without DTAC before abort (>AS_MIN)
) (
  input  logic        SYSCLK,
  input  logic        RSTn,
  // request side
  input  logic        REQ,
  input  logic        REQ_WE,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  RDATA,
  // bus side
  output logic [15:0] ADDR,
  output logic        AS,
  output logic        RWb,
  output logic [7:0]  DOUT,
  output logic        DOUT_OE,
  input  logic [7:0]  DIN,
  input  logic        DTAC
);

  // The counter must reach TIMEOUT. SETUP also reuses it, to count up to ADDR_SETUP.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(ADDR_SETUP);
  localparam logic [CW-1:0] AS_MIN_C   = CW'(AS_MIN);
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cnt_inc;
  logic           we_q, we_d;
  logic [7:0]     wdata_q, wdata_d;
  logic           err_q, err_d;

  // Two-stage synchroniser for the asynchronous DTAC. Both stages idle
  // high, so the released state is "no acknowledge".
  logic           dtac_s1, dtac_s2;

  // Next-value signals for the registered outputs.
  logic [15:0]    addr_d;
  logic           as_d;
  logic           rwb_d;
  logic           oe_d;
  logic [7:0]     dout_d;
  logic [7:0]     rdata_d;
  logic           busy_d;
  logic           done_d;
  logic           errp_d;

  logic           strobe_ack;
  logic           strobe_tout;

  assign cnt_inc     = cnt_q + CNT_ONE;

  // The acknowledge counts only after the minimum strobe width. The timeout
  // fires only when the last allowed tick still sees no acknowledge.
  assign strobe_ack  = (cnt_q >= AS_MIN_C) && !dtac_s2;
  assign strobe_tout = (cnt_q == TIMEOUT_C) && dtac_s2;

  // Bring DTAC into the SYSCLK domain.
  always_ff @(posedge SYSCLK or negedge RSTn) begin
    if (!RSTn) begin
      dtac_s1 <= 1'b1;
      dtac_s2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, so s2 gets the old s1 and the chain stays two deep.
      dtac_s1 <= DTAC;
      dtac_s2 <= dtac_s1;
    end
  end

  // State register and request latches.
  always_ff @(posedge SYSCLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Registered outputs. The reset values describe an idle, released bus.
  always_ff @(posedge SYSCLK or negedge RSTn) begin
    if (!RSTn) begin
      ADDR    <= 16'hFFFF;
      AS      <= 1'b1;
      RWb     <= 1'b1;
      DOUT    <= '0;
      DOUT_OE <= 1'b0;
      RDATA   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      ADDR    <= addr_d;
      AS      <= as_d;
      RWb     <= rwb_d;
      DOUT    <= dout_d;
      DOUT_OE <= oe_d;
      RDATA   <= rdata_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
      ERR     <= errp_d;
    end
  end

  // Next-state logic and next-cycle output values.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    addr_d  = ADDR;
    as_d    = 1'b1;
    rwb_d   = RWb;
    oe_d    = DOUT_OE;
    dout_d  = DOUT;
    rdata_d = RDATA;
    busy_d  = BUSY;
    done_d  = 1'b0;
    errp_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        rwb_d  = 1'b1;
        oe_d   = 1'b0;
        busy_d = 1'b0;
        if (REQ) begin
          // Accept. ADDR changes here, while AS is still high.
          state_d = ST_SETUP;
          cnt_d   = CNT_ONE;
          we_d    = REQ_WE;
          wdata_d = REQ_WDATA;
          addr_d  = REQ_ADDR;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_SETUP: begin
        busy_d = 1'b1;
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_ONE;
          as_d    = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          // Turn the bus around for a write in the last SETUP tick, one tick
          // ahead of AS falling.
          if (we_q && (cnt_inc == SETUP_LAST)) begin
            rwb_d  = 1'b0;
            oe_d   = 1'b1;
            dout_d = wdata_q;
          end
        end
      end

      ST_STROBE: begin
        busy_d = 1'b1;
        if (strobe_ack || strobe_tout) begin
          state_d = ST_RELEASE;
          as_d    = 1'b1;
          err_d   = strobe_tout;
          if (!we_q && !strobe_tout) begin
            rdata_d = DIN;
          end
        end else begin
          as_d  = 1'b0;
          cnt_d = cnt_inc;
        end
      end

      ST_RELEASE: begin
        // RWb and DOUT_OE hold through this tick and drop on entering IDLE.
        state_d = ST_IDLE;
        rwb_d   = 1'b1;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        errp_d  = err_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// Testbench for bus_cycle_initiator.
// Each cycle is predicted from the bus timing rules, as tick windows counted
// from the accept tick. The trace the DUT produces is compared tick by tick.
module tb_bus_cycle_initiator;

  localparam int ADDR_SETUP = 5;
  localparam int AS_MIN     = 10;
  localparam int TIMEOUT    = 256;

  logic        SYSCLK;
  logic        RSTn;
  logic        REQ;
  logic        REQ_WE;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [7:0]  RDATA;
  logic [15:0] ADDR;
  logic        AS;
  logic        RWb;
  logic [7:0]  DOUT;
  logic        DOUT_OE;
  logic [7:0]  DIN;
  logic        DTAC;

  int n_cmp;
  int n_bad;

  // Bus state the model expects to persist between cycles.
  logic [15:0] prev_addr;
  logic [7:0]  prev_dout;
  logic [7:0]  prev_rdata;

  bus_cycle_initiator #(
    .ADDR_SETUP (ADDR_SETUP),
    .AS_MIN     (AS_MIN),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .SYSCLK    (SYSCLK),
    .RSTn      (RSTn),
    .REQ       (REQ),
    .REQ_WE    (REQ_WE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .RDATA     (RDATA),
    .ADDR      (ADDR),
    .AS        (AS),
    .RWb       (RWb),
    .DOUT      (DOUT),
    .DOUT_OE   (DOUT_OE),
    .DIN       (DIN),
    .DTAC      (DTAC)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  // Runs one bus cycle. Call it at the falling edge inside an IDLE tick;
  // that tick becomes t0.
  // dtac_tick < 0 means DTAC is already low at accept. Otherwise DTAC is
  // driven low in the middle of tick t<dtac_tick>, relative to t0.
  // The task returns after sampling the expected DONE tick, which is itself
  // an IDLE tick, so the next call can follow back to back.
  task automatic run_cycle(input logic we, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] din,
                           input int dtac_tick, input logic hold_req,
                           output int obs_done_tick, output int obs_as_low,
                           output int obs_dones, output int obs_err);
    int s, min_exit, max_exit, sync, e;
    logic tout, bad_seen;
    logic e_as, e_rwb, e_oe, e_busy, e_done, e_err;
    logic [7:0] e_dout, e_rdata;
    logic [37:0] exp_v, obs_v;

    // Timing model. AS falls after ADDR_SETUP ticks. It is held at least
    // AS_MIN ticks and at most TIMEOUT ticks. DTAC takes 2 ticks to be seen.
    s        = ADDR_SETUP + 1;
    min_exit = s + AS_MIN - 1;
    max_exit = s + TIMEOUT - 1;
    sync     = (dtac_tick < 0) ? 2 : dtac_tick + 2;
    e        = (sync > min_exit) ? sync : min_exit;
    tout     = (e > max_exit);
    if (tout) e = max_exit;

    REQ       = 1'b1;
    REQ_WE    = we;
    REQ_ADDR  = addr;
    REQ_WDATA = wdata;
    DIN       = din;
    DTAC      = (dtac_tick < 0) ? 1'b0 : 1'b1;

    bad_seen      = 1'b0;
    obs_done_tick = -1;
    obs_as_low    = 0;
    obs_dones     = 0;
    obs_err       = 0;

    for (int k = 1; k <= e + 2; k++) begin
      @(negedge SYSCLK);
      if (!hold_req) REQ = 1'b0;
      if (k == dtac_tick) DTAC = 1'b0;

      e_as    = !(k >= s && k <= e);
      e_oe    = we && (k >= ADDR_SETUP) && (k <= e + 1);
      e_rwb   = !e_oe;
      e_busy  = (k <= e + 1);
      e_done  = (k == e + 2);
      e_err   = e_done && tout;
      e_dout  = (we && k >= ADDR_SETUP) ? wdata : prev_dout;
      e_rdata = (!we && !tout && k >= e + 1) ? din : prev_rdata;

      exp_v = {e_as, e_rwb, e_oe, e_busy, e_done, e_err, addr, e_dout, e_rdata};
      obs_v = {AS, RWb, DOUT_OE, BUSY, DONE, ERR, ADDR, DOUT, RDATA};

      if (AS === 1'b0) obs_as_low++;
      if (DONE === 1'b1) begin
        obs_dones++;
        if (obs_done_tick < 0) obs_done_tick = k;
        if (ERR === 1'b1) obs_err++;
      end

      // Report only the first divergence of a trace.
      if (!bad_seen) begin
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++;
          bad_seen = 1'b1;
          $display("FAIL trace addr=%h t%0d: got {AS,RWb,OE,BUSY,DONE,ERR}=%b ADDR=%h DOUT=%h RDATA=%h, want %b ADDR=%h DOUT=%h RDATA=%h",
                   addr, k, obs_v[37:32], obs_v[31:16], obs_v[15:8], obs_v[7:0],
                   exp_v[37:32], exp_v[31:16], exp_v[15:8], exp_v[7:0]);
        end
      end
    end

    prev_addr = addr;
    if (we) prev_dout = wdata;
    if (!we && !tout) prev_rdata = din;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    logic [37:0] idle_v, obs_v;
    RSTn      = 1'b0;
    REQ       = 1'b0;
    REQ_WE    = 1'b0;
    REQ_ADDR  = '0;
    REQ_WDATA = '0;
    DIN       = '0;
    DTAC      = 1'b1;
    prev_addr  = 16'hFFFF;
    prev_dout  = 8'h00;
    prev_rdata = 8'h00;
    idle_v = {6'b110000, 16'hFFFF, 8'h00, 8'h00};
    repeat (3) @(negedge SYSCLK);
    obs_v = {AS, RWb, DOUT_OE, BUSY, DONE, ERR, ADDR, DOUT, RDATA};
    n_cmp++;
    if (obs_v !== idle_v) begin
      n_bad++;
      $display("FAIL reset_held: got %h, want %h", obs_v, idle_v);
    end
    RSTn = 1'b1;
    repeat (2) @(negedge SYSCLK);
    obs_v = {AS, RWb, DOUT_OE, BUSY, DONE, ERR, ADDR, DOUT, RDATA};
    n_cmp++;
    if (obs_v !== idle_v) begin
      n_bad++;
      $display("FAIL reset_idle: got %h, want %h", obs_v, idle_v);
    end
  endtask

  task automatic test_read();
    int dt, al, nd, ne;
    run_cycle(1'b0, 16'h4000, 8'h00, 8'hA5, -1, 1'b0, dt, al, nd, ne);
    check_int("read_done_tick", dt, 17);
    check_int("read_as_low", al, 10);
    check_int("read_rdata", int'(RDATA), 8'hA5);
    check_int("read_err", ne, 0);
  endtask

  task automatic test_write();
    int dt, al, nd, ne;
    run_cycle(1'b1, 16'h7FFF, 8'h5A, 8'h00, -1, 1'b0, dt, al, nd, ne);
    check_int("write_done_tick", dt, 17);
    check_int("write_dout", int'(DOUT), 8'h5A);
  endtask

  task automatic test_late_dtac();
    int dt, al, nd, ne;
    // DTAC falls just before the edge 20 ticks after AS fell.
    run_cycle(1'b0, 16'h4100, 8'h00, 8'h3C, ADDR_SETUP + 1 + 19, 1'b0, dt, al, nd, ne);
    check_int("late_as_low", al, 22);
    check_int("late_done_tick", dt, ADDR_SETUP + 1 + 22 + 1);
    check_int("late_err", ne, 0);
  endtask

  task automatic test_timeout();
    int dt, al, nd, ne;
    logic [7:0] keep;
    keep = RDATA;
    run_cycle(1'b0, 16'h4200, 8'h00, ~keep, 100000, 1'b0, dt, al, nd, ne);
    check_int("tout_as_low", al, TIMEOUT);
    check_int("tout_err_pulses", ne, 1);
    check_int("tout_rdata_kept", int'(RDATA), int'(keep));
    // The next request goes through normally.
    run_cycle(1'b1, 16'h4201, 8'h77, 8'h00, -1, 1'b0, dt, al, nd, ne);
    check_int("after_tout_done", dt, 17);
    check_int("after_tout_err", ne, 0);
  endtask

  task automatic test_dtac_boundaries();
    int dt, al, nd, ne;
    int s;
    s = ADDR_SETUP + 1;
    // Acknowledge seen exactly in the AS_MIN-th strobe tick, and one tick later.
    run_cycle(1'b0, 16'h4300, 8'h00, 8'h11, s + AS_MIN - 3, 1'b0, dt, al, nd, ne);
    check_int("min_edge_as_low", al, AS_MIN);
    run_cycle(1'b0, 16'h4301, 8'h00, 8'h22, s + AS_MIN - 2, 1'b0, dt, al, nd, ne);
    check_int("min_plus1_as_low", al, AS_MIN + 1);
    // Acknowledge seen in the last allowed strobe tick: a normal end.
    run_cycle(1'b0, 16'h4302, 8'h00, 8'h33, s + TIMEOUT - 3, 1'b0, dt, al, nd, ne);
    check_int("last_tick_err", ne, 0);
    // Acknowledge seen one tick too late: a timeout.
    run_cycle(1'b0, 16'h4303, 8'h00, 8'h44, s + TIMEOUT - 2, 1'b0, dt, al, nd, ne);
    check_int("late_by_one_err", ne, 1);
  endtask

  task automatic test_back_to_back();
    int dt, al, nd, ne, total;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 16'h4000 + 16'(i), 8'h00, 8'(8'h80 + i), -1, 1'b1, dt, al, nd, ne);
      total += nd;
      check_int("b2b_period", dt, 17);
    end
    REQ = 1'b0;
    check_int("b2b_done_pulses", total, 4);
    @(negedge SYSCLK);
    check_int("b2b_idle_after", int'(BUSY), 0);
  endtask

  task automatic test_reset_midcycle();
    int dones, dt, al, nd, ne;
    logic [2:0] got;
    DTAC      = 1'b1;
    REQ       = 1'b1;
    REQ_WE    = 1'b1;
    REQ_ADDR  = 16'h5555;
    REQ_WDATA = 8'hC3;
    for (int k = 1; k <= ADDR_SETUP + 3; k++) begin
      @(negedge SYSCLK);
      REQ = 1'b0;
    end
    got = {AS, RWb, DOUT_OE};
    check_int("pre_reset_strobe", int'(got), 3'b001);
    RSTn = 1'b0;
    #1;
    got = {AS, RWb, DOUT_OE};
    check_int("reset_bus_release", int'(got), 3'b110);
    check_int("reset_busy", int'(BUSY), 0);
    repeat (2) @(negedge SYSCLK);
    RSTn = 1'b1;
    prev_addr  = 16'hFFFF;
    prev_dout  = 8'h00;
    prev_rdata = 8'h00;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge SYSCLK);
      if (DONE !== 1'b0) dones++;
    end
    check_int("reset_no_done", dones, 0);
    run_cycle(1'b1, 16'h6000, 8'h9E, 8'h00, -1, 1'b0, dt, al, nd, ne);
    check_int("post_reset_done", dt, 17);
  endtask

  task automatic test_random();
    int dt, al, nd, ne, dtk, pick;
    logic we;
    for (int i = 0; i < 12; i++) begin
      we   = 1'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 9));
      if (pick < 3)      dtk = -1;
      else if (pick < 9) dtk = int'($urandom_range(1, 40));
      else               dtk = int'($urandom_range(250, 270));
      run_cycle(we, 16'($urandom), 8'($urandom), 8'($urandom), dtk, 1'b0, dt, al, nd, ne);
      check_int("rand_done_pulses", nd, 1);
      // A random gap before the next request.
      REQ = 1'b0;
      repeat (int'($urandom_range(0, 3))) @(negedge SYSCLK);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_read();
    test_write();
    test_late_dtac();
    test_timeout();
    test_dtac_boundaries();
    test_back_to_back();
    test_reset_midcycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
